cam_capture_ctrl: RTL and testbench

Frame-capture sequencer for the OV7670 camera path. It runs on the camera pixel clock and tracks VSYNC/HREF framing. It drives the byte-phase select that the RGB565-to-RGB332 downsampler consumes, and generates the frame-buffer write enable and address for each completed pixel. Capture is armed by a single-shot or continuous request from the control logic, and line/frame length faults are reported as sticky flags.

---
 rtl/cam_capture_ctrl_if.sv | 35 +++
 rtl/cam_capture_ctrl.sv | 143 ++++++++++++++
 tb/tb_cam_capture_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cam_capture_ctrl_if.sv
// Bundle of camera framing inputs, control pulses and frame-buffer write outputs
// for the capture sequencer; slave is the sequencer side.
interface cam_capture_ctrl_if #(
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 8
);
    logic              VSYNC;
    logic              HREF;
    logic              CAPTURE_REQ;
    logic              CONTINUOUS;
    logic              ABORT;
    logic              CLR_ERR;
    logic              BYTE_PHASE;
    logic              PIX_WE;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [CNT_W-1:0]  WR_X;
    logic [CNT_W-1:0]  WR_Y;
    logic              BUSY;
    logic              FRAME_DONE;
    logic [7:0]        FRAME_CNT;
    logic              LINE_ERR;
    logic              FRAME_ERR;

    modport master (
        output VSYNC, HREF, CAPTURE_REQ, CONTINUOUS, ABORT, CLR_ERR,
        input  BYTE_PHASE, PIX_WE, WR_ADDR, WR_X, WR_Y, BUSY,
               FRAME_DONE, FRAME_CNT, LINE_ERR, FRAME_ERR
    );

    modport slave (
        input  VSYNC, HREF, CAPTURE_REQ, CONTINUOUS, ABORT, CLR_ERR,
        output BYTE_PHASE, PIX_WE, WR_ADDR, WR_X, WR_Y, BUSY,
               FRAME_DONE, FRAME_CNT, LINE_ERR, FRAME_ERR
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// OV7670 frame-capture sequencer: tracks VSYNC/HREF, pairs bytes into pixels and
// issues frame-buffer writes with incremental addressing plus sticky framing faults.
module cam_capture_ctrl #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 15,
    parameter int CNT_W  = 8
) (
    input  logic             PCLK,
    input  logic             RESET_N,
    cam_capture_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE, DONE} state_t;

    localparam logic [CNT_W-1:0]  WIDTH_C  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]  HEIGHT_C = CNT_W'(HEIGHT);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] WIDTH_A  = ADDR_W'(WIDTH);

    state_t            state_reg;
    logic              vs_q_reg, href_q_reg;
    logic              byte_phase_reg;
    logic              pix_we_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W-1:0] line_base_reg;
    logic [CNT_W-1:0]  wr_x_reg, wr_y_reg;
    logic              line_ovf_reg, frame_ovf_reg;
    logic              frame_done_reg;
    logic [7:0]        frame_cnt_reg;
    logic              line_err_reg, frame_err_reg;

    logic vs_fall, vs_rise, href_fall;
    logic in_active;
    logic line_err_set, frame_err_set;

    always_comb begin
        vs_fall   = vs_q_reg & ~bus.VSYNC;
        vs_rise   = ~vs_q_reg & bus.VSYNC;
        href_fall = href_q_reg & ~bus.HREF;
        in_active = (state_reg == ACTIVE) && !bus.ABORT;
        // A VSYNC rise ends the frame first, so a coincident line end is not judged
        line_err_set  = in_active && !vs_rise && href_fall &&
                        ((wr_x_reg != WIDTH_C) || line_ovf_reg || byte_phase_reg);
        frame_err_set = in_active && vs_rise &&
                        ((wr_y_reg != HEIGHT_C) || frame_ovf_reg);
    end

    always_ff @(posedge PCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= IDLE;
            vs_q_reg       <= 1'b0;
            href_q_reg     <= 1'b0;
            byte_phase_reg <= 1'b0;
            pix_we_reg     <= 1'b0;
            wr_addr_reg    <= '0;
            line_base_reg  <= '0;
            wr_x_reg       <= '0;
            wr_y_reg       <= '0;
            line_ovf_reg   <= 1'b0;
            frame_ovf_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= '0;
            line_err_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            vs_q_reg       <= bus.VSYNC;
            href_q_reg     <= bus.HREF;
            pix_we_reg     <= 1'b0;
            frame_done_reg <= 1'b0;

            if (line_err_set)     line_err_reg <= 1'b1;
            else if (bus.CLR_ERR) line_err_reg <= 1'b0;
            if (frame_err_set)     frame_err_reg <= 1'b1;
            else if (bus.CLR_ERR)  frame_err_reg <= 1'b0;

            if (bus.ABORT) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.CAPTURE_REQ) state_reg <= WAIT_VS;
                    end
                    WAIT_VS: begin
                        if (vs_fall) begin
                            state_reg      <= ACTIVE;
                            wr_x_reg       <= '0;
                            wr_y_reg       <= '0;
                            line_base_reg  <= '0;
                            wr_addr_reg    <= '0;
                            byte_phase_reg <= 1'b0;
                            line_ovf_reg   <= 1'b0;
                            frame_ovf_reg  <= 1'b0;
                        end
                    end
                    ACTIVE: begin
                        if (vs_rise) begin
                            state_reg      <= DONE;
                            frame_done_reg <= 1'b1;
                            frame_cnt_reg  <= frame_cnt_reg + 8'd1;
                        end else if (bus.HREF) begin
                            byte_phase_reg <= ~byte_phase_reg;
                            if (byte_phase_reg) begin
                                // Second byte: the downsampler presents the packed pixel next cycle
                                if ((wr_x_reg < WIDTH_C) && (wr_y_reg < HEIGHT_C)) begin
                                    pix_we_reg  <= 1'b1;
                                    wr_addr_reg <= line_base_reg + ADDR_W'(wr_x_reg);
                                    wr_x_reg    <= wr_x_reg + ONE_C;
                                end else begin
                                    line_ovf_reg <= 1'b1;
                                end
                            end
                        end else if (href_fall) begin
                            byte_phase_reg <= 1'b0;
                            wr_x_reg       <= '0;
                            line_ovf_reg   <= 1'b0;
                            if (wr_y_reg < HEIGHT_C) begin
                                wr_y_reg      <= wr_y_reg + ONE_C;
                                line_base_reg <= line_base_reg + WIDTH_A;
                            end else begin
                                frame_ovf_reg <= 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        state_reg <= bus.CONTINUOUS ? WAIT_VS : IDLE;
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.BYTE_PHASE = byte_phase_reg;
    assign bus.PIX_WE     = pix_we_reg;
    assign bus.WR_ADDR    = wr_addr_reg;
    assign bus.WR_X       = wr_x_reg;
    assign bus.WR_Y       = wr_y_reg;
    assign bus.BUSY       = (state_reg != IDLE);
    assign bus.FRAME_DONE = frame_done_reg;
    assign bus.FRAME_CNT  = frame_cnt_reg;
    assign bus.LINE_ERR   = line_err_reg;
    assign bus.FRAME_ERR  = frame_err_reg;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Frame-level bench for cam_capture_ctrl: drives whole camera frames and compares
// against a pixel/line model of what each frame should write and flag.
module tb_cam_capture_ctrl;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 5;
    localparam int CW = 4;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    cam_capture_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) cif();

    cam_capture_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .CNT_W(CW)) dut (
        .PCLK    (pclk),
        .RESET_N (rst_n),
        .bus     (cif.slave)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int obs_q[$];
    int exp_q[$];
    int fd_cnt = 0;
    int line_len [8];
    bit armed = 1'b0;
    bit exp_le = 1'b0;
    bit exp_fe = 1'b0;
    int exp_fcnt = 0;
    int frame_no = 0;

    always @(negedge pclk) begin
        if (cif.PIX_WE)     obs_q.push_back(int'(cif.WR_ADDR));
        if (cif.FRAME_DONE) fd_cnt++;
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // One camera frame: VSYNC falls, nl lines of line_len[] bytes, VSYNC rises and stays high.
    task automatic run_frame(input bit req, input bit cont, input int nl,
                             input int abort_at, input bit clr);
        int  bidx;
        int  acc;
        int  px;
        bit  cap;
        bit  aborted;
        cif.CONTINUOUS = cont;
        if (!cif.VSYNC) begin
            cif.VSYNC = 1'b1;
            repeat (3) step();
        end
        if (clr) begin
            cif.CLR_ERR = 1'b1;
            step();
            cif.CLR_ERR = 1'b0;
            exp_le = 1'b0;
            exp_fe = 1'b0;
            @(negedge pclk);
            check_eq("clr_line_err", int'(cif.LINE_ERR), 0);
            check_eq("clr_frame_err", int'(cif.FRAME_ERR), 0);
        end
        if (req) begin
            cif.CAPTURE_REQ = 1'b1;
            step();
            cif.CAPTURE_REQ = 1'b0;
            armed = 1'b1;
        end
        step();
        @(negedge pclk);
        check_eq("busy_armed", int'(cif.BUSY), int'(armed));
        cap = armed;
        aborted = 1'b0;
        obs_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        cif.VSYNC = 1'b0;
        repeat (2) step();
        bidx = 0;
        for (int l = 0; l < nl; l++) begin
            if (cap && !aborted)
                check_eq("byte_phase_line_start", int'(cif.BYTE_PHASE), 0);
            acc = 0;
            for (int b = 0; b < line_len[l]; b++) begin
                cif.HREF = 1'b1;
                if (bidx == abort_at) begin
                    cif.ABORT = 1'b1;
                    if (cap) aborted = 1'b1;
                    armed = 1'b0;
                end
                if (cap && !aborted) acc++;
                step();
                cif.ABORT = 1'b0;
                bidx++;
            end
            cif.HREF = 1'b0;
            repeat (2 + $urandom_range(0, 2)) step();
            if (cap) begin
                px = acc / 2;
                if (l < H)
                    for (int x = 0; x < px && x < W; x++) exp_q.push_back(l * W + x);
                if (!aborted && (line_len[l] != 2 * W || l >= H)) exp_le = 1'b1;
            end
        end
        cif.VSYNC = 1'b1;
        repeat (4) step();
        if (cap && !aborted) begin
            if (nl != H) exp_fe = 1'b1;
            exp_fcnt = (exp_fcnt + 1) % 256;
            armed = cont;
        end
        @(negedge pclk);
        check_eq("write_count", obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq("write_addr", obs_q[i], exp_q[i]);
        check_eq("frame_done_pulses", fd_cnt, (cap && !aborted) ? 1 : 0);
        check_eq("frame_cnt", int'(cif.FRAME_CNT), exp_fcnt);
        check_eq("line_err", int'(cif.LINE_ERR), int'(exp_le));
        check_eq("frame_err", int'(cif.FRAME_ERR), int'(exp_fe));
        check_eq("busy_after", int'(cif.BUSY), int'(armed));
        $display("frame %0d: req=%0d cont=%0d lines=%0d abort_at=%0d writes=%0d/%0d done=%0d cnt=%0d le=%0d fe=%0d",
                 frame_no, req, cont, nl, abort_at, obs_q.size(), exp_q.size(), fd_cnt,
                 cif.FRAME_CNT, cif.LINE_ERR, cif.FRAME_ERR);
        frame_no++;
    endtask

    task automatic set_lens(input int a, input int b, input int c, input int d);
        line_len[0] = a;
        line_len[1] = b;
        line_len[2] = c;
        line_len[3] = d;
    endtask

    function automatic int pick_len();
        int r;
        r = $urandom_range(0, 11);
        case (r)
            0:       return 5;
            1:       return 6;
            2:       return 7;
            3:       return 9;
            4:       return 10;
            default: return 8;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        int total;
        int ab;
        cif.VSYNC = 1'b0;
        cif.HREF = 1'b0;
        cif.CAPTURE_REQ = 1'b0;
        cif.CONTINUOUS = 1'b0;
        cif.ABORT = 1'b0;
        cif.CLR_ERR = 1'b0;
        repeat (3) @(posedge pclk);
        #1 rst_n = 1'b1;
        @(negedge pclk);
        check_eq("rst_busy", int'(cif.BUSY), 0);
        check_eq("rst_pix_we", int'(cif.PIX_WE), 0);
        check_eq("rst_wr_addr", int'(cif.WR_ADDR), 0);
        check_eq("rst_byte_phase", int'(cif.BYTE_PHASE), 0);
        check_eq("rst_frame_cnt", int'(cif.FRAME_CNT), 0);
        check_eq("rst_frame_done", int'(cif.FRAME_DONE), 0);
        check_eq("rst_line_err", int'(cif.LINE_ERR), 0);
        check_eq("rst_frame_err", int'(cif.FRAME_ERR), 0);

        set_lens(8, 8, 8, 8);
        run_frame(1'b1, 1'b0, 3, -1, 1'b0);    // clean single shot
        run_frame(1'b1, 1'b1, 3, -1, 1'b0);    // continuous, first frame
        run_frame(1'b0, 1'b0, 3, -1, 1'b0);    // re-armed automatically, ends idle
        set_lens(8, 10, 8, 8);
        run_frame(1'b1, 1'b0, 3, -1, 1'b0);    // long line
        set_lens(8, 7, 8, 8);
        run_frame(1'b1, 1'b0, 3, -1, 1'b1);    // odd byte count
        set_lens(8, 8, 8, 8);
        run_frame(1'b1, 1'b0, 2, -1, 1'b1);    // short frame
        run_frame(1'b1, 1'b0, 4, -1, 1'b1);    // long frame
        run_frame(1'b1, 1'b0, 3, 10, 1'b1);    // abort after five writes
        run_frame(1'b0, 1'b0, 3, -1, 1'b0);    // camera activity while idle

        for (int f = 0; f < 30; f++) begin
            nl = ($urandom_range(0, 9) < 7) ? 3 : int'($urandom_range(2, 4));
            total = 0;
            for (int l = 0; l < 4; l++) begin
                line_len[l] = pick_len();
                if (l < nl) total += line_len[l];
            end
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            run_frame($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), nl, ab,
                      $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
